// File: rtl/imm_gen_stage_if.sv
// Valid/ready bundle for imm_gen_stage: instruction stream in, expanded immediate stream out.
// The stage uses the slave modport; whoever feeds and drains it uses master.
interface imm_gen_stage_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_inst;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_fmt;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid,
        input  in_inst,
        input  in_tag,
        output in_ready,
        output out_valid,
        input  out_ready,
        output out_imm,
        output out_fmt,
        output out_tag
    );

    modport master (
        output in_valid,
        output in_inst,
        output in_tag,
        input  in_ready,
        input  out_valid,
        output out_ready,
        input  out_imm,
        input  out_fmt,
        input  out_tag
    );
endinterface

// File: rtl/imm_gen_stage.sv
// Pipelined RV immediate generator: one-cycle latency, output register plus one skid entry.
// Define IMM_GEN_ZICSR_EN to decode SYSTEM immediates (uimm5 for CSR*I, csr field otherwise).
module imm_gen_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    imm_gen_stage_if.slave bus
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_Z    = 3'd6;

    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_IMM_32   = 7'b0011011;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_STORE_FP = 7'b0100111;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
`ifdef IMM_GEN_ZICSR_EN
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
`endif

    logic [31:0]      inst;
    logic [2:0]       dec_fmt;
    logic [31:0]      imm32;
    logic [XLEN-1:0]  dec_imm;

    logic             out_valid_q;
    logic [XLEN-1:0]  out_imm_q;
    logic [2:0]       out_fmt_q;
    logic [TAG_W-1:0] out_tag_q;

    logic             skid_valid_q;
    logic [XLEN-1:0]  skid_imm_q;
    logic [2:0]       skid_fmt_q;
    logic [TAG_W-1:0] skid_tag_q;

    logic             in_fire;
    logic             out_free;
    logic             load_out_from_skid;
    logic             load_out_from_in;
    logic             load_skid;
    logic             out_valid_nxt;
    logic             skid_valid_nxt;

    assign inst = bus.in_inst;

    always_comb begin
        dec_fmt = FMT_NONE;
        case (inst[6:0])
            OP_LOAD, OP_LOAD_FP, OP_IMM, OP_JALR: dec_fmt = FMT_I;
            OP_IMM_32: begin
                if (XLEN == 64) begin
                    dec_fmt = FMT_I;
                end
            end
            OP_STORE, OP_STORE_FP: dec_fmt = FMT_S;
            OP_BRANCH:             dec_fmt = FMT_B;
            OP_LUI, OP_AUIPC:      dec_fmt = FMT_U;
            OP_JAL:                dec_fmt = FMT_J;
`ifdef IMM_GEN_ZICSR_EN
            OP_SYSTEM:             dec_fmt = inst[14] ? FMT_Z : FMT_I;
`endif
            default:               dec_fmt = FMT_NONE;
        endcase
    end

    // Every signed format already carries inst[31] in bit 31, so one sign-extension covers XLEN=64.
    always_comb begin
        imm32 = '0;
        case (dec_fmt)
            FMT_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   imm32 = {inst[31:12], 12'b0};
            FMT_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            FMT_Z:   imm32 = {27'b0, inst[19:15]};
            default: imm32 = '0;
        endcase
    end

    assign dec_imm = XLEN'($signed(imm32));

    // Input offered during a flush is refused; skid only fills when the output cannot take the entry.
    always_comb begin
        out_free           = !out_valid_q || bus.out_ready;
        in_fire            = bus.in_valid && !skid_valid_q && !flush;
        load_out_from_skid = !flush && out_free && skid_valid_q;
        load_out_from_in   = !flush && out_free && !skid_valid_q && in_fire;
        load_skid          = in_fire && (!out_free || skid_valid_q);
        out_valid_nxt      = 1'b0;
        skid_valid_nxt     = 1'b0;
        if (!flush) begin
            out_valid_nxt  = out_free ? (skid_valid_q || in_fire) : 1'b1;
            skid_valid_nxt = load_skid || (skid_valid_q && !out_free);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_nxt;
            skid_valid_q <= skid_valid_nxt;
        end
    end

    // Payload registers only move on a load, so they hold while stalled or after a flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_imm_q  <= '0;
            out_fmt_q  <= FMT_NONE;
            out_tag_q  <= '0;
            skid_imm_q <= '0;
            skid_fmt_q <= FMT_NONE;
            skid_tag_q <= '0;
        end else begin
            if (load_out_from_skid) begin
                out_imm_q <= skid_imm_q;
                out_fmt_q <= skid_fmt_q;
                out_tag_q <= skid_tag_q;
            end else if (load_out_from_in) begin
                out_imm_q <= dec_imm;
                out_fmt_q <= dec_fmt;
                out_tag_q <= bus.in_tag;
            end
            if (load_skid) begin
                skid_imm_q <= dec_imm;
                skid_fmt_q <= dec_fmt;
                skid_tag_q <= bus.in_tag;
            end
        end
    end

    assign bus.in_ready  = !skid_valid_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_imm   = out_imm_q;
    assign bus.out_fmt   = out_fmt_q;
    assign bus.out_tag   = out_tag_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Self-checking bench for imm_gen_stage: directed scenarios plus random traffic vs a queue model.
// Honours IMM_GEN_ZICSR_EN the same way as the design.
module tb_imm_gen_stage;

    localparam int XLEN  = 32;
    localparam int TAG_W = 32;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic [TAG_W-1:0] tag;
    } ent_t;

    logic clk;
    logic rst_n;
    logic flush;

    int   checks   = 0;
    int   failures = 0;
    ent_t q[$];
    ent_t last;

    imm_gen_stage_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    imm_gen_stage #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Immediate computed arithmetically from the ISA field definitions.
    function automatic ent_t refEntry(input logic [31:0] inst, input logic [TAG_W-1:0] tag);
        int     s;
        int     hi;
        longint v;
        ent_t   e;
        s     = $signed(inst);
        hi    = s >>> 31;
        v     = 0;
        e.fmt = 3'd0;
        case (inst[6:0])
            7'b0000011, 7'b0000111, 7'b0010011, 7'b1100111: begin
                e.fmt = 3'd1; v = longint'(s >>> 20);
            end
            7'b0011011: begin
                if (XLEN == 64) begin
                    e.fmt = 3'd1; v = longint'(s >>> 20);
                end
            end
            7'b0100011, 7'b0100111: begin
                e.fmt = 3'd2; v = longint'(s >>> 25) * 32 + longint'(inst[11:7]);
            end
            7'b1100011: begin
                e.fmt = 3'd3;
                v = longint'(hi) * 4096 + longint'(inst[7]) * 2048
                  + longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2;
            end
            7'b0110111, 7'b0010111: begin
                e.fmt = 3'd4; v = longint'(s >>> 12) * 4096;
            end
            7'b1101111: begin
                e.fmt = 3'd5;
                v = longint'(hi) * 1048576 + longint'(inst[19:12]) * 4096
                  + longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2;
            end
`ifdef IMM_GEN_ZICSR_EN
            7'b1110011: begin
                if (inst[14]) begin
                    e.fmt = 3'd6; v = longint'(inst[19:15]);
                end else begin
                    e.fmt = 3'd1; v = longint'(s >>> 20);
                end
            end
`endif
            default: ;
        endcase
        e.imm = v[XLEN-1:0];
        e.tag = tag;
        return e;
    endfunction

    function automatic logic [XLEN-1:0] sx32(input logic [31:0] x);
        longint t;
        t = longint'($signed(x));
        return t[XLEN-1:0];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic checkState();
        ent_t e;
        e = last;
        if (q.size() > 0) e = q[0];
        checkOutput("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
        checkOutput("in_ready",  64'(bus.in_ready),  64'(q.size() < 2));
        checkOutput("out_imm",   64'(bus.out_imm),   64'(e.imm));
        checkOutput("out_fmt",   64'(bus.out_fmt),   64'(e.fmt));
        checkOutput("out_tag",   64'(bus.out_tag),   64'(e.tag));
        last = e;
    endtask

    // One clock: drive at negedge, advance model at posedge, check at next negedge.
    task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic [TAG_W-1:0] tag,
                                 input logic ordy, input logic fl);
        logic inFire;
        logic outFire;
        bus.in_valid  = v;
        bus.in_inst   = inst;
        bus.in_tag    = tag;
        bus.out_ready = ordy;
        flush         = fl;
        inFire  = v && (q.size() < 2) && !fl;
        outFire = (q.size() > 0) && ordy;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (outFire) void'(q.pop_front());
            if (inFire) q.push_back(refEntry(inst, tag));
        end
        @(negedge clk);
        checkState();
    endtask

    task automatic expectHead(input string name, input logic [XLEN-1:0] imm, input logic [2:0] fmt);
        checkOutput({name, "_valid"}, 64'(bus.out_valid), 64'(1));
        checkOutput({name, "_imm"},   64'(bus.out_imm),   64'(imm));
        checkOutput({name, "_fmt"},   64'(bus.out_fmt),   64'(fmt));
    endtask

    logic [31:0] stream [8];
    logic [31:0] streamImm [8];
    logic [6:0]  ops [14];

    initial begin
        logic [31:0] r;
        logic [31:0] inst;
        logic [TAG_W-1:0] tag;

        stream[0] = 32'hFE000EE3; streamImm[0] = 32'hFFFFFFFC;
        stream[1] = 32'h0000006F; streamImm[1] = 32'h00000000;
        stream[2] = 32'h12345037; streamImm[2] = 32'h12345000;
        stream[3] = 32'h00112623; streamImm[3] = 32'h0000000C;
        stream[4] = 32'hFFC12083; streamImm[4] = 32'hFFFFFFFC;
        stream[5] = 32'h00001097; streamImm[5] = 32'h00001000;
        stream[6] = 32'h000080E7; streamImm[6] = 32'h00000000;
        stream[7] = 32'h7FF00093; streamImm[7] = 32'h000007FF;
        ops = '{7'b0000011, 7'b0000111, 7'b0010011, 7'b1100111, 7'b0011011, 7'b0100011, 7'b0100111,
                7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1110011, 7'b0001011, 7'b0110011};

        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_inst   = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        last          = '0;

        @(negedge clk);
        checkOutput("rst_out_valid", 64'(bus.out_valid), 64'(0));
        checkOutput("rst_out_imm",   64'(bus.out_imm),   64'(0));
        checkOutput("rst_out_fmt",   64'(bus.out_fmt),   64'(0));
        checkOutput("rst_out_tag",   64'(bus.out_tag),   64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        checkState();

        applyStimulus(1'b1, 32'hFFF00093, 32'h1000, 1'b1, 1'b0);
        expectHead("addi", sx32(32'hFFFFFFFF), 3'd1);
        checkOutput("addi_tag", 64'(bus.out_tag), 64'(32'h1000));
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, stream[i], TAG_W'(32'h2000 + 4 * i), 1'b1, 1'b0);
            expectHead("stream", sx32(streamImm[i]), refEntry(stream[i], '0).fmt);
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        applyStimulus(1'b1, 32'h00500093, 32'h3000, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00A00093, 32'h3004, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00F00093, 32'h3008, 1'b0, 1'b0);
        checkOutput("bp_in_ready", 64'(bus.in_ready), 64'(0));
        expectHead("bp_held", sx32(32'h5), 3'd1);
        applyStimulus(1'b1, 32'h00F00093, 32'h3008, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h00F00093, 32'h3008, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        applyStimulus(1'b1, 32'h00100093, 32'h4000, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00200093, 32'h4004, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00300093, 32'h4008, 1'b1, 1'b1);
        checkOutput("flush_out_valid", 64'(bus.out_valid), 64'(0));
        checkOutput("flush_in_ready",  64'(bus.in_ready),  64'(1));
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        applyStimulus(1'b1, 32'h0000000B, 32'h5000, 1'b1, 1'b0);
        expectHead("unknown", '0, 3'd0);
        applyStimulus(1'b1, 32'h3402D073, 32'h5004, 1'b1, 1'b0);
`ifdef IMM_GEN_ZICSR_EN
        expectHead("csrrwi", XLEN'(5), 3'd6);
`else
        expectHead("csrrwi", '0, 3'd0);
`endif
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        for (int i = 0; i < 400; i++) begin
            r    = $urandom();
            inst = {r[31:7], ops[$urandom_range(0, 13)]};
            tag  = TAG_W'($urandom());
            applyStimulus($urandom_range(0, 3) != 0, inst, tag,
                          $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
        end

        applyStimulus(1'b1, 32'hFFF00093, 32'h6000, 1'b0, 1'b0);
        checkOutput("prerst_out_valid", 64'(bus.out_valid), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_out_valid", 64'(bus.out_valid), 64'(0));
        checkOutput("async_out_imm",   64'(bus.out_imm),   64'(0));
        checkOutput("async_out_fmt",   64'(bus.out_fmt),   64'(0));
        checkOutput("async_out_tag",   64'(bus.out_tag),   64'(0));
        bus.in_valid = 1'b0;
        q.delete();
        last = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkState();
        applyStimulus(1'b1, 32'h12345037, 32'h7000, 1'b1, 1'b0);
        expectHead("post_rst_lui", sx32(32'h12345000), 3'd4);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
